// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage asynchronous SRAM controller.
// Holds the request encodings, bus widths, FSM states and the SRAM strobe bundle.
package mem_sram_ctrl_pkg;

  localparam int MEMRW_W     = 2;
  localparam int DATA_W      = 32;
  localparam int DATA_ADDR_W = 32;
  localparam int SRAM_AW_DEF = 20;
  localparam int CNT_W       = 4;

  typedef enum logic [MEMRW_W-1:0] {
    MEMRW_IDLE  = 2'b00,
    MEMRW_READ  = 2'b01,
    MEMRW_WRITE = 2'b10,
    MEMRW_RSVD  = 2'b11
  } memrw_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Active-low chip/output/write enables plus the data-pad drive enable.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } strobe_t;

  localparam strobe_t STROBE_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

  // The reserved encoding 2'b11 behaves exactly like Idle.
  function automatic logic is_req(input logic [MEMRW_W-1:0] memrw);
    return (memrw == MEMRW_READ) || (memrw == MEMRW_WRITE);
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage responder that performs one word access on an asynchronous SRAM
// with programmable wait states, stalling the pipeline until completion.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = SRAM_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MEMRW_W-1:0]     mem_memrw_i,
  input  logic [DATA_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  output logic [DATA_W-1:0]      mem_rdata_o,
  output logic                   mem_ack_o,
  output logic                   align_err_o,
  output logic                   stall_req_o,
  output logic [SRAM_AW-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]      sram_wdata_o,
  output logic                   sram_data_oe_o,
  input  logic [DATA_W-1:0]      sram_rdata_i,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               req_write, req_write_next;
  strobe_t            strobe, strobe_next;
  logic [SRAM_AW-1:0] addr, addr_next;
  logic [DATA_W-1:0]  wdata, wdata_next;
  logic [DATA_W-1:0]  rdata, rdata_next;
  logic               ack, ack_next;
  logic               align_err, align_err_next;
  logic               new_write;

  // Address bits above the SRAM word range alias onto the same word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr_i[DATA_ADDR_W-1:SRAM_AW+2];

  assign new_write = (mem_memrw_i == MEMRW_WRITE);

  // Every registered output is computed for the state being entered, so the
  // pins change on the same edge as the state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next     = state;
    cnt_next       = cnt;
    req_write_next = req_write;
    strobe_next    = STROBE_OFF;
    addr_next      = addr;
    wdata_next     = wdata;
    rdata_next     = rdata;
    ack_next       = 1'b0;
    align_err_next = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (is_req(mem_memrw_i)) begin
          if (mem_addr_i[1:0] != 2'b00) begin
            state_next     = ST_DONE;
            ack_next       = 1'b1;
            align_err_next = 1'b1;
            rdata_next     = '0;
          end else begin
            state_next          = ST_SETUP;
            req_write_next      = new_write;
            addr_next           = mem_addr_i[SRAM_AW+1:2];
            if (new_write) wdata_next = mem_wdata_i;
            strobe_next.ce_n    = 1'b0;
            strobe_next.oe_n    = new_write;
            strobe_next.data_oe = new_write;
          end
        end
      end

      ST_SETUP: begin
        state_next          = ST_ACCESS;
        cnt_next            = CNT_LOAD;
        strobe_next.ce_n    = 1'b0;
        strobe_next.oe_n    = req_write;
        strobe_next.we_n    = !req_write;
        strobe_next.data_oe = req_write;
      end

      ST_ACCESS: begin
        if (cnt == '0) begin
          state_next = ST_DONE;
          ack_next   = 1'b1;
          // Write data stays on the pads through DONE to cover hold after we_n rises.
          strobe_next.data_oe = req_write;
          if (!req_write) rdata_next = sram_rdata_i;
        end else begin
          cnt_next            = cnt - 1'b1;
          strobe_next.ce_n    = 1'b0;
          strobe_next.oe_n    = req_write;
          strobe_next.we_n    = !req_write;
          strobe_next.data_oe = req_write;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values; reset is synchronous and checked first.
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      strobe    <= STROBE_OFF;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_write <= req_write_next;
      strobe    <= strobe_next;
      addr      <= addr_next;
      wdata     <= wdata_next;
      rdata     <= rdata_next;
      ack       <= ack_next;
      align_err <= align_err_next;
    end
  end

  assign stall_req_o = !rst && (((state == ST_IDLE) && is_req(mem_memrw_i)) ||
                                (state == ST_SETUP) || (state == ST_ACCESS));

  assign mem_rdata_o    = rdata;
  assign mem_ack_o      = ack;
  assign align_err_o    = align_err;
  assign sram_addr_o    = addr;
  assign sram_wdata_o   = wdata;
  assign sram_data_oe_o = strobe.data_oe;
  assign sram_ce_n_o    = strobe.ce_n;
  assign sram_oe_n_o    = strobe.oe_n;
  assign sram_we_n_o    = strobe.we_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: W=2 instance with a word SRAM model,
// plus W=1 and W=15 instances for read-latency boundaries.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- W=2 instance with SRAM model ----------------
  logic [1:0]  memrw = MEMRW_IDLE;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata, sram_wdata, sram_rdata;
  logic        mem_ack, align_err, stall, data_oe, ce_n, oe_n, we_n;
  logic [19:0] sram_addr;
  logic [31:0] sram [0:255];

  assign sram_rdata = (!ce_n && !oe_n) ? sram[sram_addr[7:0]] : 32'h0;
  always @(posedge clk) if (!ce_n && !we_n && data_oe) sram[sram_addr[7:0]] <= sram_wdata;

  mem_sram_ctrl #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
    .clk(clk), .rst(rst), .mem_memrw_i(memrw), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack), .align_err_o(align_err), .stall_req_o(stall),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_data_oe_o(data_oe),
    .sram_rdata_i(sram_rdata), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n));

  // ---------------- W=1 and W=15 instances ----------------
  logic [1:0]  memrw1 = MEMRW_IDLE, memrw15 = MEMRW_IDLE;
  logic [31:0] addr1 = '0, addr15 = '0;
  logic [31:0] rdata1, rdata15, wdata1, wdata15, srd1, srd15;
  logic        ack1, ack15, aerr1, aerr15, stall1, stall15, doe1, doe15;
  logic        ce1, ce15, oe1, oe15, we1, we15;
  logic [19:0] saddr1, saddr15;

  assign srd1  = (!ce1 && !oe1)   ? {12'hC0F, saddr1}  : 32'h0;
  assign srd15 = (!ce15 && !oe15) ? {12'hC0F, saddr15} : 32'h0;

  mem_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut1 (
    .clk(clk), .rst(rst), .mem_memrw_i(memrw1), .mem_addr_i(addr1), .mem_wdata_i(32'h0),
    .mem_rdata_o(rdata1), .mem_ack_o(ack1), .align_err_o(aerr1), .stall_req_o(stall1),
    .sram_addr_o(saddr1), .sram_wdata_o(wdata1), .sram_data_oe_o(doe1),
    .sram_rdata_i(srd1), .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1));

  mem_sram_ctrl #(.WAIT_CYCLES(15), .SRAM_AW(20)) dut15 (
    .clk(clk), .rst(rst), .mem_memrw_i(memrw15), .mem_addr_i(addr15), .mem_wdata_i(32'h0),
    .mem_rdata_o(rdata15), .mem_ack_o(ack15), .align_err_o(aerr15), .stall_req_o(stall15),
    .sram_addr_o(saddr15), .sram_wdata_o(wdata15), .sram_data_oe_o(doe15),
    .sram_rdata_i(srd15), .sram_ce_n_o(ce15), .sram_oe_n_o(oe15), .sram_we_n_o(we15));

  int ack_total = 0;
  always @(negedge clk) if (mem_ack) ack_total++;

  // Per-cycle samples of one transaction on the W=2 instance (bit c = cycle c).
  logic [31:0] v_stall, v_ce, v_oe, v_we, v_doe, v_ack, v_align;
  logic [31:0] rd;
  logic [19:0] seen_addr;
  int          ack_cyc;

  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic txn(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d);
    {v_stall, v_ce, v_oe, v_we, v_doe, v_ack, v_align} = '0;
    ack_cyc = -1; rd = '0; seen_addr = '0;
    memrw = rw; mem_addr = a; mem_wdata = d;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      v_stall[c] = stall;  v_ce[c]  = ~ce_n;   v_oe[c]    = ~oe_n;
      v_we[c]    = ~we_n;  v_doe[c] = data_oe; v_ack[c]   = mem_ack;
      v_align[c] = align_err;
      if (!ce_n) seen_addr = sram_addr;
      if (mem_ack) begin ack_cyc = c; rd = mem_rdata; end
      @(posedge clk); #1;
      if (ack_cyc >= 0) break;
    end
    memrw = MEMRW_IDLE;
    check("ack_seen", 64'(ack_cyc >= 0), 64'd1);
  endtask

  task automatic tread(input int w, input logic [31:0] a,
                       output int stall_len, output int ackc, output logic [31:0] rdv);
    stall_len = 0; ackc = -1; rdv = '0;
    if (w == 1) begin memrw1 = MEMRW_READ; addr1 = a; end
    else begin memrw15 = MEMRW_READ; addr15 = a; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((w == 1) ? stall1 : stall15) stall_len++;
      if ((w == 1) ? ack1 : ack15) begin ackc = c; rdv = (w == 1) ? rdata1 : rdata15; end
      @(posedge clk); #1;
      if (ackc >= 0) break;
    end
    memrw1 = MEMRW_IDLE; memrw15 = MEMRW_IDLE;
  endtask

  int sl, ac, acks_before;
  logic [31:0] rv;
  logic any_ce;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[4] = 32'hDEADBEEF;

    // Reset with a read pending: stall must stay low while rst is high.
    memrw = MEMRW_READ; mem_addr = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_strobes", {ce_n, oe_n, we_n, data_oe}, 4'b1110);
    check("rst_ack_err", {mem_ack, align_err}, 2'b00);
    check("rst_rdata", mem_rdata, 0);
    check("rst_addr_wdata", {sram_addr, sram_wdata}, 0);
    memrw = MEMRW_IDLE;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Aligned read, W=2.
    txn(MEMRW_READ, 32'h0000_0010, 32'h0);
    check("rd_stall", v_stall, 32'h0000_000F);
    check("rd_oe", v_oe, 32'h0000_000E);
    check("rd_ce", v_ce, 32'h0000_000E);
    check("rd_we", v_we, 32'h0);
    check("rd_ack", v_ack, 32'h0000_0010);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_addr", seen_addr, 20'h4);

    // Aligned write, W=2.
    txn(MEMRW_WRITE, 32'h0000_0020, 32'h1234_5678);
    check("wr_we", v_we, 32'h0000_000C);
    check("wr_doe", v_doe, 32'h0000_001E);
    check("wr_oe", v_oe, 32'h0);
    check("wr_ack", v_ack, 32'h0000_0010);
    check("wr_stall", v_stall, 32'h0000_000F);
    check("wr_addr", seen_addr, 20'h8);
    check("wr_mem", sram[8], 32'h1234_5678);
    check("wr_rdata_kept", mem_rdata, 32'hDEADBEEF);

    // Misaligned read.
    txn(MEMRW_READ, 32'h0000_0013, 32'h0);
    check("mis_ce", v_ce, 32'h0);
    check("mis_stall", v_stall, 32'h0000_0001);
    check("mis_ack", v_ack, 32'h0000_0002);
    check("mis_align", v_align, 32'h0000_0002);
    check("mis_rdata", rd, 32'h0);

    // Back-to-back write then read of the same word.
    acks_before = ack_total;
    txn(MEMRW_WRITE, 32'h0000_0040, 32'hA5A5_A5A5);
    check("b2b_wr_ack", v_ack, 32'h0000_0010);
    txn(MEMRW_READ, 32'h0000_0040, 32'h0);
    check("b2b_rd_ack", v_ack, 32'h0000_0010);
    check("b2b_rd_data", rd, 32'hA5A5_A5A5);
    any_ce = 1'b0;
    repeat (3) begin @(negedge clk); if (!ce_n) any_ce = 1'b1; @(posedge clk); #1; end
    check("b2b_ack_count", ack_total - acks_before, 2);
    check("b2b_no_dup", any_ce, 0);

    // Upper address bits alias onto the same SRAM word.
    txn(MEMRW_READ, 32'hFFC0_0010, 32'h0);
    check("alias_addr", seen_addr, 20'h4);
    check("alias_data", rd, 32'hDEADBEEF);

    // Reset asserted in cycle 2 of a write.
    acks_before = ack_total;
    memrw = MEMRW_WRITE; mem_addr = 32'h80; mem_wdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_stall_in_rst", stall, 0);
    memrw = MEMRW_IDLE;
    @(posedge clk); #1; rst = 1'b0;
    check("rstmid_strobes", {ce_n, oe_n, we_n, data_oe}, 4'b1110);
    @(negedge clk);
    check("rstmid_stall", stall, 0);
    repeat (3) @(posedge clk); #1;
    check("rstmid_no_ack", ack_total - acks_before, 0);
    txn(MEMRW_READ, 32'h0000_0010, 32'h0);
    check("rstmid_idle_ack", v_ack, 32'h0000_0010);

    // Read latency boundaries.
    tread(1, 32'h0000_0100, sl, ac, rv);
    check("w1_stall_len", sl, 3);
    check("w1_ack_cyc", ac, 3);
    check("w1_data", rv, 32'hC0F0_0040);
    tread(15, 32'h0000_0100, sl, ac, rv);
    check("w15_stall_len", sl, 17);
    check("w15_ack_cyc", ac, 17);
    check("w15_data", rv, 32'hC0F0_0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
